// File: rtl/chunked_logic_unit_pkg.sv
// ---------------------------------------------------------------------------
// logic_unit_pkg
// Shared definitions for the chunked bitwise logic unit:
//   - OP_* opcode constants (AND / OR / XOR / NOR)
//   - state_e FSM encoding (IDLE / RUN / DONE, 2 bits)
//   - idx_width(): slice-index counter width, never below one bit
// ---------------------------------------------------------------------------
package logic_unit_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // A single-slice configuration still needs a 1-bit index register.
  function automatic int idx_width(input int nchunk);
    if (nchunk > 1) begin
      return $clog2(nchunk);
    end else begin
      return 1;
    end
  endfunction

endpackage : logic_unit_pkg

// File: rtl/chunked_logic_unit_if.sv
// ---------------------------------------------------------------------------
// chunked_logic_unit_if
// Command / result bus of the chunked logic unit.
//   cmd_valid, cmd_ready, op, a, b  : command handshake and operands
//   res_valid, res_ready            : result handshake
//   result, zero, busy              : registered result, zero flag, activity
// Modports: master = requester (drives command, consumes result),
//           slave  = the logic unit itself.
// ---------------------------------------------------------------------------
interface chunked_logic_unit_if #(
  parameter int WIDTH = 32
) ();
  import logic_unit_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;

  modport master (
    output cmd_valid, op, a, b, res_ready,
    input  cmd_ready, res_valid, result, zero, busy
  );

  modport slave (
    input  cmd_valid, op, a, b, res_ready,
    output cmd_ready, res_valid, result, zero, busy
  );

endinterface : chunked_logic_unit_if

// File: rtl/chunked_logic_unit_slice.sv
// ---------------------------------------------------------------------------
// logic_slice
// Combinational CHUNK-bit bitwise operator.
//   a, b : CHUNK-bit operand slices
//   op   : OP_AND / OP_OR / OP_XOR / OP_NOR
//   y    : CHUNK-bit result slice (NOR is ~(a|b) per bit)
// ---------------------------------------------------------------------------
module logic_slice
  import logic_unit_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic [1:0]       op,
  output logic [CHUNK-1:0] y
);

  // Opcode select for one slice.
  always_comb begin
    y = {CHUNK{1'b0}};
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      default: y = {CHUNK{1'b0}};
    endcase
  end

endmodule : logic_slice

// File: rtl/chunked_logic_unit.sv
// ---------------------------------------------------------------------------
// chunked_logic_unit
// Multi-cycle bitwise logic unit: evaluates op(a, b) CHUNK bits per clock,
// LSB slice first, over NCHUNK = WIDTH/CHUNK cycles.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : chunked_logic_unit_if.slave (command, result, zero, busy)
// Flow: IDLE accepts a command and latches a/b/op; RUN writes one result
// slice per edge; DONE holds result/zero with res_valid until res_ready.
// ---------------------------------------------------------------------------
module chunked_logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  chunked_logic_unit_if.slave  bus
);

  localparam int SAFE_CHUNK = (CHUNK > 0) ? CHUNK : 1;
  localparam int NCHUNK     = WIDTH / SAFE_CHUNK;
  localparam int IDXW       = idx_width(NCHUNK);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  generate
    if ((CHUNK <= 0) || ((WIDTH % SAFE_CHUNK) != 0) || (NCHUNK < 1)) begin : g_bad_params
      $error("chunked_logic_unit: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  state_e          state_r;
  logic [IDXW-1:0] idx_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             cmd_ready_r;
  logic             res_valid_r;
  logic             busy_r;

  logic [CHUNK-1:0] a_sl_s;
  logic [CHUNK-1:0] b_sl_s;
  logic [CHUNK-1:0] y_sl_s;
  logic [WIDTH-1:0] result_nxt_s;

  // Slice mux and write-back; a single-slice build bypasses the indexing.
  generate
    if (NCHUNK == 1) begin : g_single
      assign a_sl_s = a_r;
      assign b_sl_s = b_r;

      // Whole result is the single slice.
      always_comb begin
        result_nxt_s = y_sl_s;
      end
    end else begin : g_multi
      assign a_sl_s = a_r[idx_r*CHUNK +: CHUNK];
      assign b_sl_s = b_r[idx_r*CHUNK +: CHUNK];

      // Current result with the active slice replaced by the new value.
      always_comb begin
        result_nxt_s = result_r;
        result_nxt_s[idx_r*CHUNK +: CHUNK] = y_sl_s;
      end
    end
  endgenerate

  logic_slice #(
    .CHUNK (CHUNK)
  ) u_slice (
    .a  (a_sl_s),
    .b  (b_sl_s),
    .op (op_r),
    .y  (y_sl_s)
  );

  // Control FSM with slice counter, operand capture and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      idx_r       <= {IDXW{1'b0}};
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      op_r        <= OP_AND;
      result_r    <= {WIDTH{1'b0}};
      zero_r      <= 1'b0;
      cmd_ready_r <= 1'b1;
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.cmd_valid && cmd_ready_r) begin
            a_r         <= bus.a;
            b_r         <= bus.b;
            op_r        <= bus.op;
            result_r    <= {WIDTH{1'b0}};
            idx_r       <= {IDXW{1'b0}};
            state_r     <= ST_RUN;
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b1;
          end
        end
        ST_RUN: begin
          result_r <= result_nxt_s;
          if (idx_r == LAST_IDX) begin
            // zero must see the final slice, hence result_nxt_s not result_r.
            zero_r      <= (result_nxt_s == {WIDTH{1'b0}});
            idx_r       <= {IDXW{1'b0}};
            state_r     <= ST_DONE;
            res_valid_r <= 1'b1;
          end else begin
            idx_r <= idx_r + IDXW'(1);
          end
        end
        ST_DONE: begin
          if (bus.res_ready) begin
            state_r     <= ST_IDLE;
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            cmd_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          idx_r       <= {IDXW{1'b0}};
          cmd_ready_r <= 1'b1;
          res_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_r;
  assign bus.res_valid = res_valid_r;
  assign bus.result    = result_r;
  assign bus.zero      = zero_r;
  assign bus.busy      = busy_r;

endmodule : chunked_logic_unit

// File: tb/tb_chunked_logic_unit.sv
// ---------------------------------------------------------------------------
// tb_chunked_logic_unit
// Scoreboard bench: a CHUNK=4 unit for directed scenarios, plus CHUNK=1/8/32
// units driven with random vectors against a reference model.
// ---------------------------------------------------------------------------
module tb_chunked_logic_unit;
  import logic_unit_pkg::*;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
  } exp_t;

  logic clk;
  logic rst_n;
  logic sw_rst_n;
  int   checks;
  int   failures;
  exp_t sb_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  chunked_logic_unit_if #(.WIDTH(32)) bus ();

  chunked_logic_unit #(.WIDTH(32), .CHUNK(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      2'b11:   return ~(a | b);
      default: return 32'h0;
    endcase
  endfunction

  // One complete transaction on the CHUNK=4 unit; hold>0 keeps res_ready low in DONE.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int hold, input bit toggle);
    exp_t e;
    int   n;
    int   lat;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    bus.cmd_valid = 1'b1;
    bus.res_ready = (hold == 0);
    sb_q.push_back('{res: exp_res, zero: (exp_res == 32'd0)});
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check({tag, ":busy"}, 32'(bus.busy), 32'd1);
    lat = 0;
    while (bus.res_valid !== 1'b1 && lat < 100) begin
      if (toggle) begin
        bus.a  = $urandom;
        bus.b  = $urandom;
        bus.op = 2'($urandom_range(0, 3));
      end
      @(negedge clk);
      lat++;
    end
    check({tag, ":latency"}, 32'(lat), 32'd8);
    e = sb_q.pop_front();
    check({tag, ":result"}, bus.result, e.res);
    check({tag, ":zero"}, 32'(bus.zero), 32'(e.zero));
    for (int i = 0; i < hold; i++) begin
      bus.cmd_valid = (i % 2 == 0);
      @(negedge clk);
      check({tag, ":hold_valid"}, 32'(bus.res_valid), 32'd1);
      check({tag, ":hold_result"}, bus.result, e.res);
      check({tag, ":hold_zero"}, 32'(bus.zero), 32'(e.zero));
      check({tag, ":hold_no_accept"}, 32'(bus.cmd_ready), 32'd0);
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    check({tag, ":post_valid"}, 32'(bus.res_valid), 32'd0);
    check({tag, ":post_ready"}, 32'(bus.cmd_ready), 32'd1);
    check({tag, ":post_busy"}, 32'(bus.busy), 32'd0);
    check({tag, ":idle_result"}, bus.result, e.res);
  endtask

  // Parameter sweep: each unit gets its own bus, scoreboard and stimulus process.
  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_sw
      localparam int CH = (g == 0) ? 1 : ((g == 1) ? 8 : 32);
      localparam int NC = 32 / CH;
      bit done;

      chunked_logic_unit_if #(.WIDTH(32)) sbus ();

      chunked_logic_unit #(.WIDTH(32), .CHUNK(CH)) u_sw (
        .clk   (clk),
        .rst_n (sw_rst_n),
        .bus   (sbus.slave)
      );

      initial begin : sweep
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  rop;
        logic [31:0] r;
        exp_t        e;
        exp_t        q[$];
        int          n;
        int          lat;
        done           = 1'b0;
        sbus.cmd_valid = 1'b0;
        sbus.op        = 2'b00;
        sbus.a         = 32'h0;
        sbus.b         = 32'h0;
        sbus.res_ready = 1'b1;
        repeat (5) @(negedge clk);
        for (int k = 0; k < 12; k++) begin
          ra  = $urandom;
          rb  = $urandom;
          rop = 2'($urandom_range(0, 3));
          if (k == 0) begin
            ra  = 32'h1234_5678;
            rb  = 32'h1234_5678;
            rop = OP_XOR;
          end
          if (k == 1) begin
            ra  = 32'hFFFF_FFFF;
            rb  = 32'h0000_0001;
            rop = OP_NOR;
          end
          n = 0;
          while (sbus.cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
          end
          check($sformatf("sw%0d:cmd_ready", CH), 32'(sbus.cmd_ready), 32'd1);
          sbus.a         = ra;
          sbus.b         = rb;
          sbus.op        = rop;
          sbus.cmd_valid = 1'b1;
          r = ref_op(rop, ra, rb);
          q.push_back('{res: r, zero: (r == 32'd0)});
          @(negedge clk);
          sbus.cmd_valid = 1'b0;
          lat = 0;
          while (sbus.res_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
          end
          check($sformatf("sw%0d:latency", CH), 32'(lat), 32'(NC));
          e = q.pop_front();
          check($sformatf("sw%0d:result", CH), sbus.result, e.res);
          check($sformatf("sw%0d:zero", CH), 32'(sbus.zero), 32'(e.zero));
          @(negedge clk);
        end
        done = 1'b1;
      end
    end
  endgenerate

  initial begin : main
    int t;
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    sw_rst_n      = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.op        = 2'b00;
    bus.a         = 32'h0;
    bus.b         = 32'h0;
    bus.res_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst:result", bus.result, 32'h0);
    check("rst:zero", 32'(bus.zero), 32'd0);
    check("rst:res_valid", 32'(bus.res_valid), 32'd0);
    check("rst:busy", 32'(bus.busy), 32'd0);
    rst_n    = 1'b1;
    sw_rst_n = 1'b1;
    @(negedge clk);
    check("rst:cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Directed ops on the same operands, back-to-back.
    run_op("and", OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 1'b0);
    run_op("or",  OP_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 0, 1'b0);
    run_op("xor", OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 1'b0);
    run_op("nor", OP_NOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 0, 1'b0);
    // Zero result with consumer back-pressure.
    run_op("zero_hold", OP_AND, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 5, 1'b0);

    // Mid-RUN asynchronous reset at idx=3.
    bus.op        = OP_OR;
    bus.a         = 32'hFFFF_FFFF;
    bus.b         = 32'h0000_0000;
    bus.cmd_valid = 1'b1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst:partial", bus.result, 32'h0000_0FFF);
    check("midrst:zero_pre", 32'(bus.zero), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst:result", bus.result, 32'h0);
    check("midrst:zero", 32'(bus.zero), 32'd0);
    check("midrst:res_valid", 32'(bus.res_valid), 32'd0);
    check("midrst:busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post_rst", OP_XOR, 32'h1234_5678, 32'h0F0F_0F0F,
           ref_op(OP_XOR, 32'h1234_5678, 32'h0F0F_0F0F), 0, 1'b0);

    // Inputs churn during RUN; result must follow the latched operands.
    run_op("toggle", OP_NOR, 32'h0123_4567, 32'h89AB_0000,
           ref_op(OP_NOR, 32'h0123_4567, 32'h89AB_0000), 0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [1:0]  rop;
      ra  = $urandom;
      rb  = $urandom;
      rop = 2'(k);
      run_op($sformatf("rand%0d", k), rop, ra, rb, ref_op(rop, ra, rb), k, 1'b1);
    end

    t = 0;
    while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("sweep:done", 32'(g_sw[0].done && g_sw[1].done && g_sw[2].done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_chunked_logic_unit
